button_event_rx: RTL
====================

# button_event_rx

Debounced board-button input block: the input-side counterpart to the LED blink outputs in the power-test bring-up top. It synchronizes one asynchronous pushbutton, filters contact bounce with a cycle-counted debounce FSM, and produces a clean level plus single-cycle press, release and long-press events. It also keeps a saturating press counter that bring-up logic uses to step through test modes.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable synchronized cycles required to accept a level change (10 ms at 100 MHz); must be ≥ 2.
- LONG_CYCLES, default 100_000_000: cycles `btn_level` must stay high before `long_pulse` fires; must be ≥ 1.
- CNT_W, default 8: width of `press_count`.
- ACTIVE_LOW, default 0: 1 means `btn_in` low = pressed. Inversion is applied before the synchronizer.
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  1  raw asynchronous button pin.
- clear_count  in  1  synchronous clear of `press_count`.
- btn_level  out  1  debounced pressed level.
- press_pulse  out  1  one-cycle pulse on an accepted press.
- release_pulse  out  1  one-cycle pulse on an accepted release.
- long_pulse  out  1  one-cycle pulse, at most once per press.
- press_count  out  CNT_W  accepted presses, saturating.

## Operation
- Input path: `btn_in` is polarity-corrected, then passes through 2 flops (both reset to 0 = not pressed). The output of the 2nd flop is `b_s`.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1). Long timer width: $clog2(LONG_CYCLES+1).
- FSM states and transitions:
  - IDLE: `btn_level` = 0. If `b_s` = 1, go to ARMING with debounce count = 1.
  - ARMING: If `b_s` = 0, return to IDLE. Otherwise increment the count. When `b_s` = 1 and count = DEBOUNCE_CYCLES-1, go to HELD, set `btn_level` = 1, pulse `press_pulse`, and clear the long timer.
  - HELD: If `b_s` = 0, go to RELEASING with debounce count = 1.
  - RELEASING: If `b_s` = 1, return to HELD. Otherwise increment the count. When `b_s` = 0 and count = DEBOUNCE_CYCLES-1, go to IDLE, clear `btn_level`, and pulse `release_pulse`.
- The net effect is that `b_s` must hold the new value for exactly DEBOUNCE_CYCLES consecutive cycles before a change is accepted. Any opposite sample restarts the qualification.
- Long timer:
  - Counts every cycle while `btn_level` = 1, including time spent in RELEASING (bounces do not reset it).
  - `long_pulse` fires when the timer reaches LONG_CYCLES, then is inhibited until the next press.
  - If the release is accepted first, no `long_pulse` is produced.
  - If expiry and release acceptance fall in the same cycle, both pulses assert.
- `press_count`:
  - Increments on `press_pulse` and saturates at 2^CNT_W-1.
  - `clear_count` sets it to 0.
  - When `clear_count` and `press_pulse` coincide, the result is 1.

## Timing
- Reset: FSM → IDLE; sync flops, counters and long timer → 0; all outputs 0.
- Reset mid-press: the block returns to IDLE with no `release_pulse`. A button still held is re-detected as a new press.
- Press latency: `btn_in` asserted and stable before edge 0 → `b_s` = 1 after edge 2 → `press_pulse` and `btn_level` rise after edge 2+DEBOUNCE_CYCLES. Release latency is symmetric.
- `long_pulse` asserts exactly LONG_CYCLES edges after the `press_pulse` cycle.
- All outputs are registered; there is no combinational path from `btn_in` or `clear_count` to any output.
- Pulses are exactly 1 cycle wide. `press_pulse` and `release_pulse` never assert in the same cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=3.
- Clean press: `btn_in` held from edge 0 for 40 cycles, then released.
  - `press_pulse` in 1 cycle after edge 6; `long_pulse` 1 cycle after edge 26.
  - `release_pulse` 6 edges after the release; `press_count` = 1.
- Input bounce: high pulses of 1, 2 and 3 cycles separated by 3 low cycles → no pulses, `btn_level` stays 0, `press_count` = 0.
- Release glitch: while HELD, `btn_in` low for 3 cycles → no `release_pulse`; `btn_level` stays 1; `long_pulse` still fires exactly once at 20 cycles.
- Counter:
  - 9 clean presses → `press_count` reads 1..7 and holds at 7.
  - `clear_count` in the same cycle as a `press_pulse` → 1.
- Reset mid-HELD: `rst` asserted 1 cycle with the button still held.
  - All outputs 0 the next cycle, no `release_pulse`.
  - `press_pulse` again 6 edges after `rst` deasserts; `long_pulse` counted from that new press.
- Polarity: rerun the clean-press scenario with ACTIVE_LOW=1 and an inverted stimulus → identical output timing.

Source files
------------

// File: rtl/button_event_rx.sv
// Debounced pushbutton receiver: 2-flop synchronizer, cycle-counted debounce FSM,
// clean level, press/release/long-press pulses and a saturating press counter.
module button_event_rx #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned CNT_W           = 8,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             clear_count,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_END  = LW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMING,
    ST_HELD,
    ST_RELEASING
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              b_s_q, b_s_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [LW-1:0]     long_cnt_q, long_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    sync1_d = btn_in ^ ACTIVE_LOW;
    b_s_d   = sync1_q;
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (b_s_q) begin
          state_d = ST_ARMING;
          dcnt_d  = DW'(1);
        end
      end
      ST_ARMING: begin
        if (!b_s_q) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DB_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!b_s_q) begin
          state_d = ST_RELEASING;
          dcnt_d  = DW'(1);
        end
      end
      ST_RELEASING: begin
        if (b_s_q) begin
          state_d = ST_HELD;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer saturates at LONG_CYCLES, so the pulse can fire only once until the next press clears it.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (press_d) begin
      long_cnt_d = '0;
    end else if (level_q && (long_cnt_q != LONG_END)) begin
      long_cnt_d = long_cnt_q + 1'b1;
      long_d     = (long_cnt_q == LONG_LAST);
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_count) begin
      count_d = press_q ? CNT_W'(1) : '0;
    end else if (press_q && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b0;
      b_s_q      <= 1'b0;
      dcnt_q     <= '0;
      long_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      b_s_q      <= b_s_d;
      dcnt_q     <= dcnt_d;
      long_cnt_q <= long_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      count_q    <= count_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule
